clock_sequencer: RTL and testbench

- Controls the CPU pipeline clock source from the board clock: free-run at a selectable divide ratio, single-step on a button pulse, freeze on a CPU halt request.
- Produces a one-cycle clock-enable `tick`, a 50%-duty `clk_N` square wave, and a tick counter.
- Sits between the board buttons/switches, the pipeline (`halt_req` from the halt/syscall path) and every stage register that consumes the enable.

---
 rtl/clk_seq_pkg.sv | 12 +
 rtl/clock_sequencer_if.sv | 16 +
 rtl/rising_edge_det.sv | 12 +
 rtl/clock_sequencer.sv | 65 ++++++
 tb/tb_clock_sequencer.sv | 101 ++++++++++
 5 files changed

// File: rtl/clk_seq_pkg.sv
// clk_seq_pkg: shared state encoding, default divide ratios and period clamp
package clk_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALTED = 2'd3} state_t;
    localparam int DIV0_DEF = 100_000_000;
    localparam int DIV1_DEF = 10_000_000;
    localparam int DIV2_DEF = 1_000_000;
    localparam int DIV3_DEF = 2;
    localparam int CW_DEF   = 32;
    function automatic int clamp_period(input int d);
        return (d < 2) ? 2 : d;
    endfunction
endpackage

// File: rtl/clock_sequencer_if.sv
// clock_sequencer_if: control inputs and clock-enable outputs of the sequencer
interface clock_sequencer_if
    import clk_seq_pkg::*;
#(parameter int CW = CW_DEF);
    logic          go;
    logic          step;
    logic          halt_req;
    logic          halt_clr;
    logic [1:0]    speed_sel;
    logic          tick;
    logic          clk_N;
    state_t        state;
    logic [CW-1:0] cycle_count;
    modport master (output go, step, halt_req, halt_clr, speed_sel, input tick, clk_N, state, cycle_count);
    modport slave  (input go, step, halt_req, halt_clr, speed_sel, output tick, clk_N, state, cycle_count);
endinterface

// File: rtl/rising_edge_det.sv
// rising_edge_det: one-cycle pulse on each rising edge of a synchronous level
module rising_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);
    logic r_d;
    // remember last cycle's level
    always_ff @(posedge clk) r_d <= rst ? 1'b0 : i_d;
    assign o_rise = i_d & ~r_d;
endmodule

// File: rtl/clock_sequencer.sv
// clock_sequencer: free-run / single-step / halt control of the pipeline clock enable
module clock_sequencer
    import clk_seq_pkg::*;
#(
    parameter int DIV0 = DIV0_DEF,
    parameter int DIV1 = DIV1_DEF,
    parameter int DIV2 = DIV2_DEF,
    parameter int DIV3 = DIV3_DEF,
    parameter int CW   = CW_DEF
) (
    input logic             clk,
    input logic             rst,
    clock_sequencer_if.slave bus
);
    localparam logic [CW-1:0] L0 = CW'(clamp_period(DIV0) - 1);
    localparam logic [CW-1:0] L1 = CW'(clamp_period(DIV1) - 1);
    localparam logic [CW-1:0] L2 = CW'(clamp_period(DIV2) - 1);
    localparam logic [CW-1:0] L3 = CW'(clamp_period(DIV3) - 1);
    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx, w_lim, r_cycle_count;
    logic          r_tick, w_tick_nx, r_clk_n, w_step_rise;
    rising_edge_det u_step (.clk(clk), .rst(rst), .i_d(bus.step), .o_rise(w_step_rise));
    // wrap limit P-1 for the currently selected speed
    always_comb w_lim = (bus.speed_sel == 2'd0) ? L0 : (bus.speed_sel == 2'd1) ? L1 : (bus.speed_sel == 2'd2) ? L2 : L3;
    // next state, divide counter and tick; halt_req outranks everything but reset
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = '0;
        w_tick_nx  = 1'b0;
        case (r_state)
            IDLE:    w_state_nx = bus.halt_req ? HALTED : bus.go ? RUN : w_step_rise ? STEP : IDLE;
            RUN: begin
                w_state_nx = bus.halt_req ? HALTED : bus.go ? RUN : IDLE;
                w_tick_nx  = !bus.halt_req && bus.go && r_cnt >= w_lim;
                w_cnt_nx   = (!bus.halt_req && bus.go && r_cnt < w_lim) ? r_cnt + 1'b1 : '0;
            end
            STEP: begin
                w_state_nx = bus.halt_req ? HALTED : IDLE;
                w_tick_nx  = !bus.halt_req;
            end
            HALTED:  w_state_nx = (bus.halt_clr && !bus.halt_req) ? IDLE : HALTED;
            default: w_state_nx = IDLE;
        endcase
    end
    // register state; clk_N and cycle_count advance on the same edge that raises tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_tick        <= 1'b0;
            r_clk_n       <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_tick        <= w_tick_nx;
            r_clk_n       <= r_clk_n ^ w_tick_nx;
            r_cycle_count <= r_cycle_count + CW'(w_tick_nx);
        end
    end
    assign bus.tick        = r_tick;
    assign bus.clk_N       = r_clk_n;
    assign bus.state       = r_state;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_clock_sequencer.sv
// tb_clock_sequencer: randomized scoreboard bench against a behavioural sequencer model
module tb_clock_sequencer;
    import clk_seq_pkg::*;
    typedef struct packed {
        logic       tick;
        logic       clkn;
        logic [1:0] st;
        logic [3:0] cc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    clock_sequencer_if #(.CW(4)) sq ();
    clock_sequencer #(.DIV0(8), .DIV1(4), .DIV2(5), .DIV3(2), .CW(4)) dut (.clk(clk), .rst(rst), .bus(sq));
    always #5 clk = ~clk;
    exp_t q[$];
    int   n_cmp = 0, n_bad = 0, n_cyc = 0;
    int   per[4] = '{8, 4, 5, 2};
    int   m_state = 0, m_el = 0, m_clkn = 0, m_cc = 0;
    bit   m_tick = 0, m_stepd = 0;
    // model: tick once P cycles of RUN have elapsed since entering RUN or the last tick
    task automatic model(input bit r, g, s, hr, hc, input int sp);
        bit sr, t;
        sr = s && !m_stepd;
        t  = 0;
        if (r) begin
            m_state = 0; m_el = 0; m_clkn = 0; m_cc = 0; m_stepd = 0;
        end else begin
            m_stepd = s;
            case (m_state)
                0: if (hr) m_state = 3; else if (g) begin m_state = 1; m_el = 0; end else if (sr) m_state = 2;
                1: if (hr) m_state = 3;
                   else if (!g) m_state = 0;
                   else begin
                       m_el++;
                       if (m_el >= per[sp]) begin t = 1; m_el = 0; end
                   end
                2: begin t = !hr; m_state = hr ? 3 : 0; end
                default: if (hc && !hr) m_state = 0;
            endcase
            if (t) begin m_clkn ^= 1; m_cc = (m_cc + 1) % 16; end
        end
        m_tick = t;
        q.push_back('{m_tick, m_clkn[0], 2'(m_state), 4'(m_cc)});
    endtask
    task automatic cyc(input bit r, g, s, hr, hc, input int sp);
        @(negedge clk);
        rst = r; sq.go = g; sq.step = s; sq.halt_req = hr; sq.halt_clr = hc; sq.speed_sel = 2'(sp);
        model(r, g, s, hr, hc, sp);
    endtask
    // monitor: every cycle the DUT presents outputs, compare against the oldest expectation
    always @(posedge clk) begin
        exp_t e, a;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{sq.tick, sq.clk_N, sq.state, sq.cycle_count};
            n_cmp++;
            n_cyc++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cyc%0d tick/clkN/state/count got %0b/%0b/%0d/%0d want %0b/%0b/%0d/%0d",
                         n_cyc, a.tick, a.clkn, a.st, a.cc, e.tick, e.clkn, e.st, e.cc);
            end
        end
    end
    initial begin
        int sp;
        bit hr;
        sq.go = 0; sq.step = 0; sq.halt_req = 0; sq.halt_clr = 0; sq.speed_sel = 0;
        repeat (2) cyc(1, 0, 0, 0, 0, 3);
        for (int i = 0; i < 11; i++) cyc(0, 1, 0, 0, 0, 3);
        repeat (3) cyc(0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 13; i++) cyc(0, 0, i < 5 || (i >= 7 && i < 10), 0, 0, 3);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, i[0], 1, 0, 3);
        cyc(0, 1, 0, 1, 1, 3);
        cyc(0, 0, 0, 0, 1, 3);
        cyc(0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0, 3);
        repeat (2) cyc(1, 1, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 3);
        sp = 3;
        hr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) sp = $urandom_range(0, 3);
            if ($urandom_range(0, 24) == 0) hr = !hr;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                hr, $urandom_range(0, 3) == 0, sp);
        end
        @(posedge clk);
        #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
